// File: rtl/zigzag_encryption.sv
// Rail-fence (zig-zag) encryptor: buffers plaintext until the end-of-text token, then streams the
// ciphertext one character per cycle followed by a single token beat for the downstream decryptor.
module zigzag_encryption #(
  parameter int unsigned         D_WIDTH                = 8,
  parameter int unsigned         KEY_WIDTH              = 8,
  parameter int unsigned         MAX_NOF_CHARS          = 50,
  parameter logic [D_WIDTH-1:0]  START_DECRYPTION_TOKEN = 8'hFA
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic [KEY_WIDTH-1:0] key,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o,
  output logic                 busy
);

  localparam int unsigned AW   = (MAX_NOF_CHARS > 1) ? $clog2(MAX_NOF_CHARS) : 1;
  localparam logic [7:0]  MaxN = 8'(MAX_NOF_CHARS);

  typedef enum logic [1:0] {StIdle, StEmit, StToken, StDone} state_e;

  state_e               r_state, w_state_nxt;
  logic [KEY_WIDTH-1:0] r_key, w_key_nxt;
  logic [7:0]           r_n, w_n_nxt;
  logic [7:0]           r_rail, w_rail_nxt;
  logic [7:0]           r_idx, w_idx_nxt;
  logic [7:0]           r_cnt, w_cnt_nxt;
  logic                 r_phase, w_phase_nxt;
  logic [D_WIDTH-1:0]   r_data, w_data_nxt;
  logic                 r_valid, w_valid_nxt;
  logic                 r_busy, w_busy_nxt;

  logic [D_WIDTH-1:0]   r_buf [MAX_NOF_CHARS];

  logic [7:0]           w_k8, w_period, w_step, w_cand;
  logic                 w_key_ok, w_is_token, w_wr;
  logic [D_WIDTH-1:0]   w_rd_data;

  assign w_k8       = 8'(r_key);
  assign w_key_ok   = (r_key >= KEY_WIDTH'(2)) && (r_key <= KEY_WIDTH'(5));
  assign w_period   = (w_k8 << 1) - 8'd2;
  assign w_is_token = (data_i == START_DECRYPTION_TOKEN);
  assign w_wr       = (r_state == StIdle) && valid_i && !w_is_token && (r_n < MaxN);
  assign w_rd_data  = r_buf[r_idx[AW-1:0]];
  assign w_cand     = r_idx + w_step;

  // Out-of-range keys fall back to identity order (step 1).
  always_comb begin
    w_step = 8'd1;
    if (w_key_ok) begin
      if ((r_rail == 8'd0) || (r_rail == w_k8 - 8'd1)) w_step = w_period;
      else if (r_phase)                                 w_step = r_rail << 1;
      else                                              w_step = w_period - (r_rail << 1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_key_nxt   = r_key;
    w_n_nxt     = r_n;
    w_rail_nxt  = r_rail;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_phase_nxt = r_phase;
    w_data_nxt  = '0;
    w_valid_nxt = 1'b0;
    w_busy_nxt  = r_busy;
    case (r_state)
      StIdle: begin
        if (valid_i && w_is_token) begin
          w_key_nxt   = key;
          w_rail_nxt  = 8'd0;
          w_idx_nxt   = 8'd0;
          w_cnt_nxt   = 8'd0;
          w_phase_nxt = 1'b0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = (r_n == 8'd0) ? StToken : StEmit;
        end else if (w_wr) begin
          w_n_nxt = r_n + 8'd1;
        end
      end
      StEmit: begin
        w_data_nxt  = w_rd_data;
        w_valid_nxt = 1'b1;
        w_cnt_nxt   = r_cnt + 8'd1;
        if (w_cand < r_n) begin
          w_idx_nxt   = w_cand;
          w_phase_nxt = ~r_phase;
        end else begin
          w_rail_nxt  = r_rail + 8'd1;
          w_idx_nxt   = r_rail + 8'd1;
          w_phase_nxt = 1'b0;
        end
        if (r_cnt == r_n - 8'd1) w_state_nxt = StToken;
      end
      StToken: begin
        w_data_nxt  = START_DECRYPTION_TOKEN;
        w_valid_nxt = 1'b1;
        w_state_nxt = StDone;
      end
      StDone: begin
        w_busy_nxt  = 1'b0;
        w_n_nxt     = 8'd0;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_key   <= '0;
      r_n     <= 8'd0;
      r_rail  <= 8'd0;
      r_idx   <= 8'd0;
      r_cnt   <= 8'd0;
      r_phase <= 1'b0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_key   <= w_key_nxt;
      r_n     <= w_n_nxt;
      r_rail  <= w_rail_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_phase <= w_phase_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_wr) r_buf[r_n[AW-1:0]] <= data_i;
  end

  assign data_o  = r_data;
  assign valid_o = r_valid;
  assign busy    = r_busy;

endmodule

// File: doc/zigzag_encryption.md
# zigzag_encryption

Rail-fence (zig-zag) encryptor that sits directly upstream of `zigzag_decryption`. It buffers a plaintext stream until a terminator token, then emits the ciphertext one character per cycle, followed by one `START_DECRYPTION_TOKEN` beat. Its output port can drive the decryptor's `data_i`/`valid_i` unmodified. A loopback through both blocks with the same `key` reproduces the plaintext.

## Interface
- `D_WIDTH`, 8: character width.
- `KEY_WIDTH`, 8: key width.
- `MAX_NOF_CHARS`, 50: buffer depth in characters.
- `START_DECRYPTION_TOKEN`, 8'hFA: input end-of-text marker; also emitted as the final output beat.
- `clk`  input  1: single clock, all logic on the rising edge.
- `rst_n`  input  1: reset, synchronous, active-low.
- `data_i`  input  D_WIDTH: plaintext character or token.
- `valid_i`  input  1: `data_i` qualifier.
- `key`  input  KEY_WIDTH: number of rails; sampled on the token edge.
- `data_o`  output  D_WIDTH: ciphertext character, or the token on the last beat; 0 when `valid_o` is low.
- `valid_o`  output  1: `data_o` qualifier.
- `busy`  output  1: high while encrypting; input is ignored while it is high.

## Operation
- **States:**
  - IDLE: collect characters.
  - EMIT: output ciphertext.
  - TOKEN: output the end-of-text token.
  - DONE: clear outputs and return to IDLE.
- **Reset** (`rst_n`=0 at an edge): state IDLE, `data_o`=0, `valid_o`=0, `busy`=0, count n=0, all walk registers 0. Reset wins over any other event on the same edge, including mid-EMIT; a partial stream is truncated with no token.
- **IDLE, `valid_i`=1, `data_i`≠token:**
  - If n<MAX_NOF_CHARS: store at buf[n], n<=n+1.
  - Otherwise: drop the character, n stays saturated.
- **IDLE, `valid_i`=1, `data_i`==token:**
  - Latch `key` as K.
  - Set rail r=0, idx=0, out-count c=0, phase=0, `busy`<=1.
  - Go to EMIT, or to TOKEN if n==0.
- **Input while `busy`:** `valid_i` is ignored entirely, including characters and tokens.
- **Period P = 2(K-1).** Per-rail steps:
  - Rails 0 and K-1: step P.
  - Middle rail r: steps alternate P-2r (phase 0), then 2r (phase 1), starting with phase 0.
- **EMIT, each cycle:**
  - Drive buf[idx]; c<=c+1.
  - Candidate next index = idx+step.
  - If the candidate is < n: idx<=candidate and toggle phase.
  - Otherwise: r<=r+1, idx<=r+1, phase<=0.
  - When c reaches n-1 (this beat is the last character), go to TOKEN.
  - Because a rail-start index is always < n while characters remain, emission has no bubbles.
- **Out-of-range key:** K<2 or K>5 (the decryptor supports at most 5 rails). Identity order: idx increments by 1 and the plaintext is emitted unchanged.
- **Width rules:** idx, c, n and step arithmetic are 8-bit and cannot overflow for MAX_NOF_CHARS ≤ 127.
- **TOKEN:** drive `data_o`=START_DECRYPTION_TOKEN, `valid_o`=1.
- **DONE:** `valid_o`=0, `data_o`=0, `busy`=0, n<=0; next state IDLE.

## Timing
- All outputs are registered. "Edge k" means the k-th rising edge after the token is sampled at edge 0.
- `busy` is 1 after edge 0.
- Ciphertext character j (j=0..n-1) is valid after edge j+1.
- The token beat is valid after edge n+1.
- After edge n+2: `busy`=0, `valid_o`=0, `data_o`=0.
- A new character is accepted from edge n+3 onward; a `valid_i` beat sampled at edge n+2 is ignored, because `busy` is still 1 before that edge.
- Total busy window: n+2 cycles. With n=0, the token appears after edge 1 and `busy` drops after edge 2.
- `valid_o` stays continuously high for n+1 cycles.
- `busy` and the `valid_o` stream never overlap an input acceptance.

## Test plan
- **Key 3:** "ABCDEFG" then 0xFA → `valid_o` stream "AEBDFCG", 0xFA on consecutive cycles starting one edge after the token; `busy` high for 9 cycles.
- **Key 2 and key 5:**
  - Key 2, "ABCDE" → "ACEBD", 0xFA.
  - Key 5, "ABCDEFGHIJ" → "AIBHJCGDFE", 0xFA.
- **Short and empty messages:**
  - Key 4, "AB" → "AB", 0xFA, which exercises the empty-rail path.
  - Token only → single 0xFA beat after edge 1; `busy` low after edge 2.
- **Overflow and input while busy:**
  - 55 characters, key 3 → only the first 50 are encrypted and 50 characters are output.
  - Characters and tokens presented during `busy` are ignored, and the next message encrypts correctly.
- **Reset mid-EMIT:** `rst_n`=0 at edge 3 of a 7-character message → all outputs 0 at the following edge, no token emitted; a fresh message then behaves normally.
- **Loopback into `zigzag_decryption`:** random text with length 1..50 and key 2..5 → the decrypted output equals the plaintext; key 1 gives identity ciphertext.
